// File: rtl/ppl_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
// Imported by ppl_ctrl and ppl_hazard_det.
package ppl_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_IDLE = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2,
        PC_STEP = 2'd3
    } pc_state_e;

    localparam int REG_AW_DEF  = 4;
    localparam int MEM_LAT_DEF = 2;
    localparam int CNT_W_DEF   = 32;

endpackage

// File: rtl/ppl_hazard_det.sv
// Load-use hazard compare between the load in EX and the sources in ID.
// Purely combinational.
module ppl_hazard_det
    import ppl_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rd_we,
    input  logic              ex_is_load,
    output logic              load_use
);

    logic hit1;
    logic hit2;

    assign hit1     = id_rs1_used && (id_rs1 == ex_rd);
    assign hit2     = id_rs2_used && (id_rs2 == ex_rd);
    assign load_use = ex_is_load && ex_rd_we && (hit1 || hit2);

endmodule

// File: rtl/ppl_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, debug FSM,
// data-memory latency stall and stall/flush performance counters.
module ppl_ctrl
    import ppl_ctrl_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rd_we,
    input  logic              ex_is_load,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic              halted,
    output logic              step_done,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int MCW    = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam int LAT_M2 = (MEM_LAT > 2) ? MEM_LAT - 2 : 0;
    localparam bit MULTI  = (MEM_LAT > 1);

    localparam logic [MCW-1:0] CNT_INIT  = MCW'(LAT_M2);
    localparam logic [MCW-1:0] CNT_ONE   = MCW'(1);
    localparam bit             INIT_ZERO = (LAT_M2 == 0);

    pc_state_e        state_q;
    pc_state_e        state_d;
    logic [MCW-1:0]   cnt_q;
    logic             served_q;
    logic             step_done_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic active;
    logic mem_stall;
    logic load_use;
    logic sel_br;
    logic sel_lu;
    logic sel_nrm;
    logic step_fire;

    ppl_hazard_det #(
        .REG_AW (REG_AW)
    ) u_haz (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_rd_we    (ex_rd_we),
        .ex_is_load  (ex_is_load),
        .load_use    (load_use)
    );

    // Mutually exclusive selects so the decode below can stay unique.
    always_comb begin
        active    = (state_q == PC_RUN) || (state_q == PC_STEP);
        mem_stall = active &&
                    ((MULTI && mem_req && !served_q) || (cnt_q != '0));
        sel_br    = active && !mem_stall && ex_br_taken;
        sel_lu    = active && !mem_stall && !ex_br_taken && load_use;
        sel_nrm   = active && !mem_stall && !ex_br_taken && !load_use;
        step_fire = (state_q == PC_STEP) && !mem_stall;
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        unique case (1'b1)
            sel_br: begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            sel_lu: begin
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end
            sel_nrm: begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PC_IDLE: begin
                if (run_req && !halt_req) state_d = PC_RUN;
            end
            PC_HALT: begin
                if (halt_req)      state_d = PC_HALT;
                else if (run_req)  state_d = PC_RUN;
                else if (step_req) state_d = PC_STEP;
            end
            PC_RUN: begin
                // Halt waits until no memory access is in flight.
                if (halt_req && !mem_stall) state_d = PC_HALT;
            end
            PC_STEP: begin
                if (step_fire) state_d = PC_HALT;
            end
            default: state_d = PC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PC_IDLE;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_done_q <= step_fire;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            served_q <= 1'b0;
        end else if (mem_stall) begin
            if (cnt_q == '0) begin
                cnt_q    <= CNT_INIT;
                served_q <= INIT_ZERO;
            end else begin
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) served_q <= 1'b1;
            end
        end else if (active) begin
            served_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (active && !pc_en) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (sel_br)           flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign halted    = (state_q == PC_IDLE) || (state_q == PC_HALT);
    assign step_done = step_done_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
